// File: rtl/bbox_scan_pkg.sv
// rtl/bbox_scan_pkg.sv - shared FSM state type and result-field width helpers for bbox_scan_alu
package bbox_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width able to hold a count from 0 to n inclusive
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Width able to hold an index from 0 to n-1
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bbox_scan_alu_if.sv
// rtl/bbox_scan_alu_if.sv - column and row beat streams feeding bbox_scan_alu
interface bbox_scan_alu_if #(
    parameter int W = 24,
    parameter int H = 64
);
    logic         col_valid;
    logic [H-1:0] col_data;
    logic         col_last;
    logic         col_ready;
    logic         row_valid;
    logic [W-1:0] row_data;
    logic         row_last;
    logic         row_ready;

    modport master (
        output col_valid, col_data, col_last,
        input  col_ready,
        output row_valid, row_data, row_last,
        input  row_ready
    );

    modport slave (
        input  col_valid, col_data, col_last,
        output col_ready,
        input  row_valid, row_data, row_last,
        output row_ready
    );
endinterface

// File: rtl/bbox_line_scan.sv
// rtl/bbox_line_scan.sv - per-axis beat counter with first/last non-zero tracking (last index only with BBOX_SCAN_TRAIL_EN)
module bbox_line_scan
    import bbox_scan_pkg::*;
#(
    parameter int LEN = 24,
    parameter int DW  = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   beat,
    input  logic [DW-1:0]          data,
    input  logic                   last_flag,
    output logic                   complete,
    output logic [cnt_w(LEN)-1:0]  cnt_n,
    output logic [cnt_w(LEN)-1:0]  first_n,
`ifdef BBOX_SCAN_TRAIL_EN
    output logic [cnt_w(LEN)-1:0]  last_n,
`endif
    output logic                   found_n,
    output logic                   complete_n
);

    localparam int CNT = cnt_w(LEN);

    logic [CNT-1:0] cnt;
    logic [CNT-1:0] first;
    logic           found;
`ifdef BBOX_SCAN_TRAIL_EN
    logic [CNT-1:0] last;
`endif

    // Next-state view so the parent can latch results in the same cycle as the final beat
    always_comb begin
        cnt_n      = cnt;
        first_n    = first;
        found_n    = found;
        complete_n = complete;
`ifdef BBOX_SCAN_TRAIL_EN
        last_n     = last;
`endif
        if (beat) begin
            cnt_n = cnt + CNT'(1);
            if (|data) begin
                if (!found) begin
                    first_n = cnt;
                end
                found_n = 1'b1;
`ifdef BBOX_SCAN_TRAIL_EN
                last_n  = cnt;
`endif
            end
            if (last_flag || (cnt == CNT'(LEN - 1))) begin
                complete_n = 1'b1;
            end
        end
    end

    // Tracking registers; clear discards any partial scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            first    <= '0;
            found    <= 1'b0;
            complete <= 1'b0;
`ifdef BBOX_SCAN_TRAIL_EN
            last     <= '0;
`endif
        end else if (clear) begin
            cnt      <= '0;
            first    <= '0;
            found    <= 1'b0;
            complete <= 1'b0;
`ifdef BBOX_SCAN_TRAIL_EN
            last     <= '0;
`endif
        end else begin
            cnt      <= cnt_n;
            first    <= first_n;
            found    <= found_n;
            complete <= complete_n;
`ifdef BBOX_SCAN_TRAIL_EN
            last     <= last_n;
`endif
        end
    end

endmodule

// File: rtl/bbox_scan_alu.sv
// rtl/bbox_scan_alu.sv - bitmap bounding-box scanner producing edge shifts and 2x scale flags (trailing shifts with BBOX_SCAN_TRAIL_EN)
module bbox_scan_alu
    import bbox_scan_pkg::*;
#(
    parameter int W          = 24,
    parameter int H          = 64,
    parameter int HSCALE_THR = 12,
    parameter int VSCALE_THR = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    bbox_scan_alu_if.slave       bus,
    output logic [cnt_w(W)-1:0]  lshift,
    output logic [cnt_w(W)-1:0]  rshift,
    output logic [cnt_w(H)-1:0]  tshift,
    output logic [cnt_w(H)-1:0]  bshift,
    output logic                 scale_h,
    output logic                 scale_v,
    output logic                 blank,
    output logic                 err,
    output logic                 done
);

    localparam int CW = cnt_w(W);
    localparam int RW = cnt_w(H);
    localparam logic [CW:0] HTHR = (CW + 1)'(HSCALE_THR);
    localparam logic [RW:0] VTHR = (RW + 1)'(VSCALE_THR);

    state_e state;

    logic          c_beat, r_beat;
    logic          c_cmp, r_cmp, c_cmp_n, r_cmp_n;
    logic          c_found_n, r_found_n;
    logic [CW-1:0] c_cnt_n, c_first_n;
    logic [RW-1:0] r_cnt_n, r_first_n;
`ifdef BBOX_SCAN_TRAIL_EN
    logic [CW-1:0] c_last_n;
    logic [RW-1:0] r_last_n;
`endif

    logic [CW-1:0] lsh_c, rsh_c;
    logic [RW-1:0] tsh_c, bsh_c;
    logic [CW:0]   h_sum;
    logic [RW:0]   v_sum;
    logic          sh_c, sv_c, blank_c, err_c;

    assign bus.col_ready = (state == ST_SCAN) && !c_cmp;
    assign bus.row_ready = (state == ST_SCAN) && !r_cmp;

    // A start in the same cycle as a handshake drops that beat
    assign c_beat = bus.col_valid && bus.col_ready && !start;
    assign r_beat = bus.row_valid && bus.row_ready && !start;

    bbox_line_scan #(.LEN(W), .DW(H)) u_col_scan (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start),
        .beat       (c_beat),
        .data       (bus.col_data),
        .last_flag  (bus.col_last),
        .complete   (c_cmp),
        .cnt_n      (c_cnt_n),
        .first_n    (c_first_n),
`ifdef BBOX_SCAN_TRAIL_EN
        .last_n     (c_last_n),
`endif
        .found_n    (c_found_n),
        .complete_n (c_cmp_n)
    );

    bbox_line_scan #(.LEN(H), .DW(W)) u_row_scan (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start),
        .beat       (r_beat),
        .data       (bus.row_data),
        .last_flag  (bus.row_last),
        .complete   (r_cmp),
        .cnt_n      (r_cnt_n),
        .first_n    (r_first_n),
`ifdef BBOX_SCAN_TRAIL_EN
        .last_n     (r_last_n),
`endif
        .found_n    (r_found_n),
        .complete_n (r_cmp_n)
    );

    // Result arithmetic from next-state tracking values; an empty bitmap forces full-extent shifts
    always_comb begin
        lsh_c = c_found_n ? c_first_n : c_cnt_n;
        tsh_c = r_found_n ? r_first_n : r_cnt_n;
`ifdef BBOX_SCAN_TRAIL_EN
        rsh_c = c_found_n ? (c_cnt_n - CW'(1) - c_last_n) : '0;
        bsh_c = r_found_n ? (r_cnt_n - RW'(1) - r_last_n) : '0;
`else
        rsh_c = '0;
        bsh_c = '0;
`endif
        blank_c = !c_found_n;
        if (blank_c) begin
            lsh_c = c_cnt_n;
            rsh_c = '0;
            tsh_c = r_cnt_n;
            bsh_c = '0;
        end
        h_sum = {1'b0, lsh_c} + {1'b0, rsh_c};
        v_sum = {1'b0, tsh_c} + {1'b0, bsh_c};
        sh_c  = blank_c || (h_sum >= HTHR);
        sv_c  = blank_c || (v_sum >= VTHR);
        err_c = (c_cnt_n != CW'(W)) || (r_cnt_n != RW'(H));
    end

    // Control FSM; results latch when the later stream completes and hold until start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            lshift  <= '0;
            rshift  <= '0;
            tshift  <= '0;
            bshift  <= '0;
            scale_h <= 1'b0;
            scale_v <= 1'b0;
            blank   <= 1'b0;
            err     <= 1'b0;
            done    <= 1'b0;
        end else if (start) begin
            state   <= ST_SCAN;
            lshift  <= '0;
            rshift  <= '0;
            tshift  <= '0;
            bshift  <= '0;
            scale_h <= 1'b0;
            scale_v <= 1'b0;
            blank   <= 1'b0;
            err     <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_SCAN: begin
                    if (c_cmp_n && r_cmp_n) begin
                        state   <= ST_DONE;
                        lshift  <= lsh_c;
                        rshift  <= rsh_c;
                        tshift  <= tsh_c;
                        bshift  <= bsh_c;
                        scale_h <= sh_c;
                        scale_v <= sv_c;
                        blank   <= blank_c;
                        err     <= err_c;
                        done    <= 1'b1;
                    end
                end
                ST_IDLE, ST_DONE: state <= state;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bbox_scan_alu.sv
// tb/tb_bbox_scan_alu.sv - directed self-checking bench for bbox_scan_alu (expectations follow BBOX_SCAN_TRAIL_EN)
module tb_bbox_scan_alu;

`ifdef BBOX_SCAN_TRAIL_EN
    localparam bit TRAIL = 1'b1;
`else
    localparam bit TRAIL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] lshift, rshift;
    logic [6:0] tshift, bshift;
    logic       scale_h, scale_v, blank, err, done;

    int checks = 0;
    int errors = 0;

    logic [63:0] cmap [24];

    bbox_scan_alu_if #(.W(24), .H(64)) bus ();

    bbox_scan_alu #(.W(24), .H(64), .HSCALE_THR(12), .VSCALE_THR(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bus     (bus),
        .lshift  (lshift),
        .rshift  (rshift),
        .tshift  (tshift),
        .bshift  (bshift),
        .scale_h (scale_h),
        .scale_v (scale_v),
        .blank   (blank),
        .err     (err),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string t, input int l, input int r, input int tt, input int b,
                           input int sh, input int sv, input int bl, input int er);
        check({t, "_lshift"},  int'(lshift),  l);
        check({t, "_rshift"},  int'(rshift),  r);
        check({t, "_tshift"},  int'(tshift),  tt);
        check({t, "_bshift"},  int'(bshift),  b);
        check({t, "_scale_h"}, int'(scale_h), sh);
        check({t, "_scale_v"}, int'(scale_v), sv);
        check({t, "_blank"},   int'(blank),   bl);
        check({t, "_err"},     int'(err),     er);
    endtask

    function automatic logic [23:0] row_bits(input int r);
        logic [23:0] v;
        for (int c = 0; c < 24; c++) v[c] = cmap[c][r];
        return v;
    endfunction

    task automatic map_fill(input logic [63:0] v);
        for (int c = 0; c < 24; c++) cmap[c] = v;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drive both streams together; handshake is predicted at the negedge from the registered ready
    task automatic run_scan(input string t, input int ncol, input bit clast, input int nrow,
                            input bit rlast, input bit rnd, input bit exp_done);
        int ci = 0;
        int ri = 0;
        int cyc = 0;
        bit early = 1'b0;
        while ((ci < ncol || ri < nrow) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (done) early = 1'b1;
            bus.col_valid = (ci < ncol) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            bus.col_data  = (ci < 24) ? cmap[ci] : '0;
            bus.col_last  = clast && (ci == ncol - 1);
            bus.row_valid = (ri < nrow) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            bus.row_data  = (ri < 64) ? row_bits(ri) : '0;
            bus.row_last  = rlast && (ri == nrow - 1);
            if (bus.col_valid && bus.col_ready) ci++;
            if (bus.row_valid && bus.row_ready) ri++;
        end
        @(negedge clk);
        bus.col_valid = 1'b0;
        bus.row_valid = 1'b0;
        bus.col_last  = 1'b0;
        bus.row_last  = 1'b0;
        check({t, "_in_budget"}, int'(cyc < 2000), 1);
        check({t, "_no_early_done"}, int'(early), 0);
        check({t, "_done"}, int'(done), int'(exp_done));
    endtask

    initial begin
        bus.col_valid = 1'b0;
        bus.col_data  = '0;
        bus.col_last  = 1'b0;
        bus.row_valid = 1'b0;
        bus.row_data  = '0;
        bus.row_last  = 1'b0;
        map_fill('0);

        #12;
        check("rst_col_ready", int'(bus.col_ready), 0);
        check("rst_row_ready", int'(bus.row_ready), 0);
        chk_res("rst", 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_col_ready", int'(bus.col_ready), 0);
        check("idle_done", int'(done), 0);

        // Single pixel at column 5, row 40
        cmap[5][40] = 1'b1;
        pulse_start();
        run_scan("dot", 24, 1'b1, 64, 1'b1, 1'b0, 1'b1);
        chk_res("dot", 5, TRAIL ? 18 : 0, 40, TRAIL ? 23 : 0, TRAIL ? 1 : 0, 1, 0, 0);
        repeat (3) @(negedge clk);
        check("hold_done", int'(done), 1);
        check("hold_lshift", int'(lshift), 5);
        pulse_start();
        check("restart_done", int'(done), 0);
        check("restart_tshift", int'(tshift), 0);
        check("restart_col_ready", int'(bus.col_ready), 1);

        // Empty bitmap, completion by count only
        map_fill('0);
        pulse_start();
        run_scan("blank", 24, 1'b0, 64, 1'b0, 1'b0, 1'b1);
        chk_res("blank", 24, 0, 64, 0, 1, 1, 1, 0);

        // Full bitmap with random valid gaps
        map_fill('1);
        pulse_start();
        run_scan("full", 24, 1'b1, 64, 1'b1, 1'b1, 1'b1);
        chk_res("full", 0, 0, 0, 0, 0, 0, 0, 0);

        // Short column stream: col_last on column 9
        map_fill('0);
        cmap[3][2] = 1'b1;
        pulse_start();
        run_scan("short", 10, 1'b1, 64, 1'b1, 1'b0, 1'b1);
        chk_res("short", 3, TRAIL ? 6 : 0, 2, TRAIL ? 61 : 0, 0, TRAIL ? 1 : 0, 0, 1);

        // Abort after 7 columns, then a fresh bitmap
        map_fill('1);
        pulse_start();
        run_scan("abort", 7, 1'b0, 5, 1'b0, 1'b0, 1'b0);
        map_fill('0);
        cmap[20][10] = 1'b1;
        pulse_start();
        run_scan("fresh", 24, 1'b1, 64, 1'b1, 1'b0, 1'b1);
        chk_res("fresh", 20, TRAIL ? 3 : 0, 10, TRAIL ? 53 : 0, 1, TRAIL ? 1 : 0, 0, 0);

        // Asynchronous reset mid-scan
        map_fill('0);
        cmap[5][40] = 1'b1;
        pulse_start();
        run_scan("partial", 5, 1'b0, 5, 1'b0, 1'b0, 1'b0);
        check("mid_col_ready", int'(bus.col_ready), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_col_ready", int'(bus.col_ready), 0);
        check("arst_row_ready", int'(bus.row_ready), 0);
        check("arst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle_ready", int'(bus.row_ready), 0);
        check("post_rst_done", int'(done), 0);
        pulse_start();
        run_scan("recover", 24, 1'b1, 64, 1'b1, 1'b0, 1'b1);
        chk_res("recover", 5, TRAIL ? 18 : 0, 40, TRAIL ? 23 : 0, TRAIL ? 1 : 0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bbox_scan_alu.md
BBOX_SCAN_ALU -- requirements
Module: bbox_scan_alu

Interface
REQ-001 SHALL have parameter W, default 24, bitmap width in columns (row length in bits).
REQ-002 SHALL have parameter H, default 64, bitmap height in rows (column length in bits).
REQ-003 SHALL have parameter HSCALE_THR, default 12, empty-column count at or above which horizontal 2x scaling is flagged.
REQ-004 SHALL have parameter VSCALE_THR, default 32, empty-row count at or above which vertical 2x scaling is flagged.
REQ-005 SHALL have ports: clk in 1, clock; rst_n in 1, asynchronous active-low reset; start in 1, begin new scan (1-cycle pulse); col_valid in 1; col_data in H, one column, bit 0 = top row; col_last in 1, final column marker; col_ready out 1; row_valid in 1; row_data in W, one row, bit 0 = leftmost column; row_last in 1, final row marker; row_ready out 1.
REQ-006 SHALL have output ports: lshift out CW = $clog2(W+1); rshift out CW; tshift out RW = $clog2(H+1); bshift out RW; scale_h out 1; scale_v out 1; blank out 1; err out 1; done out 1.

Function
REQ-007 SHALL implement FSM IDLE -> SCAN on start; SCAN -> DONE when both column and row streams have completed; DONE -> SCAN on start.
REQ-008 SHALL transfer a beat when valid && ready in the same cycle; col_ready and row_ready SHALL be 1 only in SCAN while the respective stream is incomplete.
REQ-009 SHALL scan columns left to right, with index = count of accepted columns, and record the first and last non-zero column index; rows SHALL be handled identically top to bottom.
REQ-010 SHALL complete a stream on acceptance of a beat with its last flag set, or on acceptance of beat W-1 (columns) or H-1 (rows), whichever occurs first.
REQ-011 SHALL set err if a stream completes with a beat count not equal to W (columns) or H (rows); the count so far is used as the extent.
REQ-012 SHALL compute lshift = first non-zero column index and rshift = extent-1-last non-zero column index; tshift and bshift SHALL be computed analogously for rows.
REQ-013 SHALL, when every column is zero, set blank=1, lshift=extent, rshift=0, tshift=row extent, bshift=0, scale_h=1 and scale_v=1.
REQ-014 SHALL set scale_h = (lshift+rshift >= HSCALE_THR) and scale_v = (tshift+bshift >= VSCALE_THR), evaluated at CW+1 and RW+1 bits with no wrap.
REQ-015 SHALL assert done 1 cycle after the completing beat of the later stream; if both streams complete in the same cycle, done SHALL assert the next cycle.
REQ-016 SHALL hold done and all result outputs stable in DONE until start.
REQ-017 SHALL, on start in any state (including mid-SCAN), clear counters, results, err and done the next cycle, discard partial progress, and enter SCAN.
REQ-018 SHALL ignore a start coinciding with an accepted beat; that beat is dropped and not counted.

Reset
REQ-019 SHALL, on rst_n low, asynchronously enter IDLE and set all outputs to 0, including col_ready, row_ready and done.
REQ-020 SHALL leave IDLE only on start after rst_n deasserts.

Configuration
REQ-021 SHALL, with BBOX_SCAN_TRAIL_EN defined, compute rshift/bshift per REQ-012 and include them in the REQ-014 sums.
REQ-022 SHALL, without BBOX_SCAN_TRAIL_EN, tie rshift and bshift to 0, track no last-index registers, and base the scale flags on lshift and tshift only.

Structure
REQ-023 SHALL place the FSM state enum and the result-field width helper functions in package bbox_scan_pkg.
REQ-024 SHALL implement per-axis counting/first/last tracking in a single sub-module bbox_line_scan (params LEN, DW), instantiated once for columns and once for rows.

Verification
REQ-025 SHALL cover: W=24, H=64; pixel set only at col 5 row 40; both streams complete -> lshift=5, rshift=18, tshift=40, bshift=23, scale_h=1, scale_v=1, err=0.
REQ-026 SHALL cover: all-zero bitmap -> blank=1, lshift=24, tshift=64, rshift=0, bshift=0, scale_h=1, scale_v=1.
REQ-027 SHALL cover: full bitmap with valid toggled randomly on both streams -> all shifts 0, scale_h=0, scale_v=0, done 1 cycle after the last handshake.
REQ-028 SHALL cover: col_last on column 9 -> err=1, column extent 10.
REQ-029 SHALL cover: start pulsed after 7 columns, then a fresh bitmap -> results reflect only the second bitmap.
REQ-030 SHALL cover: rst_n asserted mid-SCAN -> outputs 0 immediately (asynchronously), IDLE, no done until the next start.
